// File: rtl/debug_dump_ctrl_pkg.sv
// Shared definitions for the pipeline debug dump controller: FSM states,
// dump sections and the dump geometry (words per section, bytes per word).
package debug_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SEC_PC   = 2'd0,
        SEC_REGS = 2'd1,
        SEC_MEM  = 2'd2
    } section_e;

    localparam int WORD_COUNT     = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/word_serializer.sv
// Splits one latched word into UART bytes, least significant byte first.
// The write strobe follows TX FIFO backpressure combinationally so a stalled
// byte is neither dropped nor repeated.
module word_serializer
    import debug_dump_ctrl_pkg::*;
#(
    parameter int DATA_SZ = 32,
    parameter int N       = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [DATA_SZ-1:0] i_word,
    input  logic               i_busy,
    input  logic               i_tx_full,
    output logic [N-1:0]       o_tx_data,
    output logic               o_wr_tx,
    output logic               o_last
);

    logic [DATA_SZ-1:0]    shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    assign o_wr_tx   = i_busy & ~i_tx_full;
    assign o_tx_data = shift_q[N-1:0];
    assign o_last    = (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    // Load a fresh word, or shift out one byte per accepted write.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_load) begin
            shift_d = i_word;
            cnt_d   = '0;
        end else if (o_wr_tx) begin
            shift_d = shift_q >> N;
            cnt_d   = cnt_q + BYTE_CNT_W'(1);
        end
    end

    // Shift register and byte counter state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_dump_ctrl.sv
// Dumps PC, then register file words 0..31, then data memory words 0..31 to
// the UART TX FIFO as bytes, one word at a time (settle, latch, 4 bytes, step).
module debug_dump_ctrl
    import debug_dump_ctrl_pkg::*;
#(
    parameter int DATA_SZ = 32,
    parameter int ADDR_W  = 5,
    parameter int N       = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [DATA_SZ-1:0] i_pc,
    input  logic [DATA_SZ-1:0] i_register_data,
    input  logic [DATA_SZ-1:0] i_memory_data,
    input  logic               i_tx_full,
    output logic [ADDR_W-1:0]  o_addr,
    output logic [N-1:0]       o_tx_data,
    output logic               o_wr_tx,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    state_e             state_q, state_d;
    section_e           sec_q, sec_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ser_load, ser_busy, ser_wr, ser_last;
    logic [DATA_SZ-1:0] word;

    assign o_addr  = addr_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_wr_tx = ser_wr;

    // Select the word belonging to the section currently being dumped.
    always_comb begin
        word = i_pc;
        case (sec_q)
            SEC_REGS: word = i_register_data;
            SEC_MEM:  word = i_memory_data;
            default:  word = i_pc;
        endcase
    end

    // Next-state logic; o_addr is only stepped in NEXT so it stays stable
    // from the settle cycle until the last byte of the word is written.
    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        addr_d   = addr_q;
        ser_load = 1'b0;
        ser_busy = 1'b0;
        o_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_WAIT;
                    sec_d   = SEC_PC;
                    addr_d  = '0;
                end
            end
            ST_WAIT:  state_d = ST_LATCH;
            ST_LATCH: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                ser_busy = 1'b1;
                if (ser_wr && ser_last) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                state_d = ST_WAIT;
                case (sec_q)
                    SEC_PC: begin
                        sec_d  = SEC_REGS;
                        addr_d = '0;
                    end
                    SEC_REGS: begin
                        if (addr_q == LAST_ADDR) begin
                            sec_d  = SEC_MEM;
                            addr_d = '0;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                    default: begin
                        if (addr_q == LAST_ADDR) state_d = ST_DONE;
                        else                     addr_d  = addr_q + ADDR_W'(1);
                    end
                endcase
            end
            ST_DONE: begin
                o_done  = 1'b1;
                addr_d  = '0;
                sec_d   = SEC_PC;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, section and debug address registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            sec_q   <= SEC_PC;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            addr_q  <= addr_d;
        end
    end

    word_serializer #(
        .DATA_SZ (DATA_SZ),
        .N       (N)
    ) u_ser (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (ser_load),
        .i_word    (word),
        .i_busy    (ser_busy),
        .i_tx_full (i_tx_full),
        .o_tx_data (o_tx_data),
        .o_wr_tx   (ser_wr),
        .o_last    (ser_last)
    );

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Bench for debug_dump_ctrl: a byte-level model of the expected dump stream
// (PC, R0..R31, M0..M31, LSB first) compared against the captured UART writes.
module tb_debug_dump_ctrl;

    localparam int DATA_SZ = 32;
    localparam int ADDR_W  = 5;
    localparam int N       = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              tx_full = 1'b0;
    logic [31:0]       pc = 32'h0;
    logic [31:0]       reg_base = 32'h1000_0000;
    logic [31:0]       mem_base = 32'hA0A0_0000;
    logic [31:0]       reg_data, mem_data;
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      tx_data;
    logic              wr, busy, done;

    // Register file and data memory behave as combinational arrays at o_addr.
    assign reg_data = reg_base + 32'(addr);
    assign mem_data = mem_base + 32'(addr);

    always #5 clk = ~clk;

    debug_dump_ctrl #(.DATA_SZ(DATA_SZ), .ADDR_W(ADDR_W), .N(N)) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_start         (start),
        .i_pc            (pc),
        .i_register_data (reg_data),
        .i_memory_data   (mem_data),
        .i_tx_full       (tx_full),
        .o_addr          (addr),
        .o_tx_data       (tx_data),
        .o_wr_tx         (wr),
        .o_busy          (busy),
        .o_done          (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;
    int done_cnt, done_cyc, first_wr_cyc, stall_wr;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc++;

    // Capture every accepted byte and every done pulse away from the edge.
    always @(negedge clk) begin
        if (wr) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            got.push_back(tx_data);
            if (tx_full) stall_wr++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        got.delete();
        exp_q.delete();
        done_cnt     = 0;
        done_cyc     = -1;
        first_wr_cyc = -1;
        stall_wr     = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    // Reference: one full dump is PC, 32 register words, 32 memory words.
    task automatic add_dump(input logic [31:0] p, input logic [31:0] rb, input logic [31:0] mb);
        push_word(p);
        for (int n = 0; n < 32; n++) push_word(rb + 32'(n));
        for (int n = 0; n < 32; n++) push_word(mb + 32'(n));
    endtask

    function automatic int first_diff();
        int lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < lim; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return lim;
        return -1;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt >= target) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (wr !== 1'b0)     begin n_fail++; $display("FAIL reset_wr: got %b want 0", wr); end
        n_checks++; if (addr !== '0)     begin n_fail++; $display("FAIL reset_addr: got %0d want 0", addr); end
        n_checks++; if (tx_data !== '0)  begin n_fail++; $display("FAIL reset_txdata: got %02h want 00", tx_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic_dump();
        bit to;
        int d;
        clear_mon();
        pc = 32'h0000_0008; reg_base = 32'h1000_0000; mem_base = 32'hA0A0_0000;
        add_dump(pc, reg_base, mem_base);
        pulse_start();
        wait_done(1, 1000, to);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: done_cnt %0d want 1", done_cnt); end
        n_checks++; if (got.size() != 260) begin n_fail++; $display("FAIL basic_count: got %0d bytes want 260", got.size()); end
        d = first_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL basic_seq: first differing byte index %0d (got %0d bytes want %0d)", d, got.size(), exp_q.size()); end
        n_checks++;
        if (got.size() < 8) begin
            n_fail++; $display("FAIL basic_first8: only %0d bytes", got.size());
        end else if ({got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]} !== 64'h0800_0000_0000_0010) begin
            n_fail++;
            $display("FAIL basic_first8: got %02h %02h %02h %02h %02h %02h %02h %02h want 08 00 00 00 00 00 00 10",
                     got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]);
        end
        n_checks++; if (first_wr_cyc - start_cyc != 3) begin n_fail++; $display("FAIL basic_first_wr_latency: got %0d want 3", first_wr_cyc - start_cyc); end
        n_checks++; if (done_cyc - start_cyc != 456) begin n_fail++; $display("FAIL basic_done_latency: got %0d want 456", done_cyc - start_cyc); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        n_checks++; if (busy !== 1'b0 || addr !== '0) begin n_fail++; $display("FAIL basic_end_idle: busy %b addr %0d want 0 0", busy, addr); end
    endtask

    task automatic test_stall_r5();
        bit to;
        int d;
        int held;
        clear_mon();
        pc = 32'h0000_0008; reg_base = 32'h1000_0000; mem_base = 32'hA0A0_0000;
        add_dump(pc, reg_base, mem_base);
        pulse_start();
        // R5 is the 7th word; its byte 2 is stream index 26.
        for (int i = 0; i < 500; i++) begin
            if (got.size() >= 26) break;
            @(posedge clk); #1;
        end
        tx_full = 1'b1;
        held = got.size();
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (got.size() != held || held != 26) begin n_fail++; $display("FAIL stall_no_write: bytes %0d after stall, %0d before, want 26", got.size(), held); end
        n_checks++; if (addr !== ADDR_W'(5)) begin n_fail++; $display("FAIL stall_addr: got %0d want 5", addr); end
        tx_full = 1'b0;
        wait_done(1, 1000, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout: done_cnt %0d want 1", done_cnt); end
        d = first_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL stall_seq: first differing byte index %0d (got %0d bytes)", d, got.size()); end
        n_checks++; if (stall_wr != 0) begin n_fail++; $display("FAIL stall_wr_while_full: got %0d writes want 0", stall_wr); end
        n_checks++; if (done_cyc - start_cyc != 466) begin n_fail++; $display("FAIL stall_done_latency: got %0d want 466", done_cyc - start_cyc); end
    endtask

    task automatic test_random_backpressure();
        bit to;
        int d;
        clear_mon();
        pc = $urandom; reg_base = $urandom; mem_base = $urandom;
        add_dump(pc, reg_base, mem_base);
        pulse_start();
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            tx_full = ($urandom_range(0, 2) == 0);
            if (done_cnt >= 1) begin
                to = 1'b0;
                break;
            end
        end
        tx_full = 1'b0;
        n_checks++; if (to) begin n_fail++; $display("FAIL rand_timeout: done_cnt %0d want 1", done_cnt); end
        d = first_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL rand_seq: first differing byte index %0d (got %0d bytes want 260)", d, got.size()); end
        n_checks++; if (stall_wr != 0) begin n_fail++; $display("FAIL rand_wr_while_full: got %0d writes want 0", stall_wr); end
    endtask

    task automatic test_restart_ignored();
        bit to;
        int d;
        clear_mon();
        pc = $urandom; reg_base = 32'h1000_0000; mem_base = 32'hA0A0_0000;
        add_dump(pc, reg_base, mem_base);
        pulse_start();
        repeat (98) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, 1000, to);
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (to) begin n_fail++; $display("FAIL restart_timeout: done_cnt %0d want 1", done_cnt); end
        n_checks++; if (got.size() != 260) begin n_fail++; $display("FAIL restart_count: got %0d bytes want 260", got.size()); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_cnt: got %0d want 1", done_cnt); end
        d = first_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL restart_seq: first differing byte index %0d", d); end
    endtask

    task automatic test_reset_mid_dump();
        bit to;
        bit seen;
        int d;
        clear_mon();
        pc = 32'h0000_0008; reg_base = 32'h1000_0000; mem_base = 32'hA0A0_0000;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (got.size() >= 140 && wr) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_reach_mem: got %0d bytes want >=140 with write active", got.size()); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (wr !== 1'b0)   begin n_fail++; $display("FAIL rstmid_wr: got %b want 0", wr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++; if (addr !== '0)   begin n_fail++; $display("FAIL rstmid_addr: got %0d want 0", addr); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        pc = $urandom;
        add_dump(pc, reg_base, mem_base);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d bytes after reset want 0", got.size()); end
        pulse_start();
        wait_done(1, 1000, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_timeout: done_cnt %0d want 1", done_cnt); end
        d = first_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL rstmid_seq: first differing byte index %0d (got %0d bytes)", d, got.size()); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int d;
        int start2;
        logic [31:0] pc2;
        clear_mon();
        pc  = $urandom;
        pc2 = pc ^ 32'h5A5A_0F0F;
        add_dump(pc, reg_base, mem_base);
        add_dump(pc2, reg_base, mem_base);
        pulse_start();
        wait_done(1, 1000, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_first_timeout: done_cnt %0d want 1", done_cnt); end
        // This is the cycle right after the done pulse.
        start  = 1'b1;
        pc     = pc2;
        start2 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, 1000, to);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_second_timeout: done_cnt %0d want 2", done_cnt); end
        n_checks++; if (got.size() != 520) begin n_fail++; $display("FAIL b2b_count: got %0d bytes want 520", got.size()); end
        n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
        d = first_diff();
        n_checks++; if (d != -1) begin n_fail++; $display("FAIL b2b_seq: first differing byte index %0d", d); end
        n_checks++; if (done_cyc - start2 != 456) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 456", done_cyc - start2); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic_dump();
        test_stall_r5();
        test_random_backpressure();
        test_restart_ignored();
        test_reset_mid_dump();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_dump_ctrl.md
DEBUG_DUMP_CTRL -- requirements
Module: debug_dump_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_SZ, default 32, width of PC, register and memory words.
REQ-003 Parameter ADDR_W, default 5, width of register/memory debug address (32 entries).
REQ-004 Parameter N, default 8, UART byte width.
REQ-005 i_clk  in  1  system clock, all state updates on rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  single-cycle request to dump pipeline state (driven from halt edge).
REQ-008 i_pc  in  DATA_SZ  current pipeline PC.
REQ-009 i_register_data  in  DATA_SZ  register-file word at o_addr.
REQ-010 i_memory_data  in  DATA_SZ  data-memory word at o_addr.
REQ-011 i_tx_full  in  1  UART TX FIFO full.
REQ-012 o_addr  out  ADDR_W  debug read address to the pipeline.
REQ-013 o_tx_data  out  N  byte to UART TX FIFO.
REQ-014 o_wr_tx  out  1  TX FIFO write strobe, one byte per high cycle.
REQ-015 o_busy  out  1  high whenever state is not IDLE.
REQ-016 o_done  out  1  single-cycle pulse after the last byte is written.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, LATCH, SEND, NEXT, DONE.
REQ-018 IDLE: on i_start=1, go to WAIT with section=PC, o_addr=0; else remain.
REQ-019 WAIT: one address-settle cycle, then LATCH unconditionally.
REQ-020 LATCH: capture the word of the current section (PC: i_pc; REGS: i_register_data; MEM: i_memory_data) into a DATA_SZ shift register, clear byte counter, go to SEND.
REQ-021 SEND: o_wr_tx = !i_tx_full combinationally; o_tx_data = shift[N-1:0]; on each write, shift right by N and increment byte counter; after the 4th write go to NEXT.
REQ-022 SEND with i_tx_full=1 SHALL hold state, shift register and counter, o_wr_tx=0; no byte lost or duplicated.
REQ-023 Byte order per word SHALL be LSB first.
REQ-024 NEXT: PC -> REGS addr 0; REGS addr<31 -> addr+1; REGS addr 31 -> MEM addr 0; MEM addr<31 -> addr+1 (each then WAIT); MEM addr 31 -> DONE.
REQ-025 Total dump SHALL be exactly 260 bytes: PC, R0..R31, M0..M31.
REQ-026 DONE: o_done=1 for one cycle, o_addr returns to 0, go to IDLE.
REQ-027 i_start SHALL be ignored while o_busy=1; i_start in the DONE cycle is ignored.
REQ-028 With i_tx_full held 0, first o_wr_tx SHALL occur 3 cycles after the i_start edge and o_done 456 cycles after it (7 cycles per word).
REQ-029 o_addr SHALL stay constant from WAIT through SEND of each word.

Reset
REQ-030 On i_reset=0, immediately: state=IDLE, section=PC, o_addr=0, shift register=0, byte counter=0, o_busy=0, o_done=0, o_wr_tx=0, o_tx_data=0.
REQ-031 Reset mid-dump SHALL abort with no further o_wr_tx; the next i_start restarts from the PC word.

Structure
REQ-032 State encoding, section encoding (PC, REGS, MEM), word count 32 and bytes-per-word 4 SHALL live in a shared debug package.
REQ-033 One sub-module SHALL be used: word_serializer (shift register + byte counter + write strobe), controlled by the FSM via load/busy/last.

Verification
REQ-034 Rn=0x1000_0000+n, Mn=0xA0A0_0000+n, PC=0x0000_0008, i_start pulse, i_tx_full=0 -> 260 writes; first four bytes 08,00,00,00; bytes 4..7 = 00,00,00,10; o_done 456 cycles after start.
REQ-035 i_tx_full forced high 10 cycles during R5 byte 2 -> no writes during stall, byte sequence identical to REQ-034.
REQ-036 i_start re-pulsed at cycle 100 of a dump -> ignored, still exactly 260 bytes, one o_done.
REQ-037 i_reset low during MEM section -> o_wr_tx, o_busy, o_addr drop to 0 immediately; subsequent i_start yields full 260-byte dump starting with PC.
REQ-038 Two dumps back-to-back (i_start one cycle after o_done) -> 520 bytes total, two o_done pulses, second dump starts with PC.
